// File: rtl/fp_pkg.sv
// Shared constants for the floating-point add/sub datapath: sizes, exponent limits,
// bit positions of the extended mantissa and the packed infinity pattern.
`default_nettype none

package fp_pkg;

  localparam int DataSize     = 32;
  localparam int FractionSize = 23;
  localparam int MantissaSize = FractionSize + 1;
  localparam int RoundingSize = MantissaSize + 3;
  localparam int ExponentSize = 8;

  localparam int Bias   = 127;
  localparam int ExpMax = 255;

  // Positions inside the adder's extended mantissa {carry, hidden, fraction, G, R, S}
  localparam int CarryBit  = RoundingSize;
  localparam int HiddenBit = RoundingSize - 1;
  localparam int GuardBit  = 2;
  localparam int RoundBit  = 1;
  localparam int StickyBit = 0;

  localparam logic [DataSize-1:0] PosInf = 32'h7F80_0000;

endpackage : fp_pkg

`default_nettype wire

// File: rtl/fp_leading_zero_counter.sv
// Leading-zero counter used by the normalize stage; also flags an all-zero input.
`default_nettype none

module fp_leading_zero_counter
  import fp_pkg::*;
#(
  parameter int Width      = 27,
  parameter int CountWidth = $clog2(Width)
) (
  input  logic [Width-1:0]      Value,
  output logic [CountWidth-1:0] Count,
  output logic                  AllZero
);

  // Scanning upward lets the highest set bit make the final assignment.
  always_comb begin
    Count   = '0;
    AllZero = 1'b1;
    for (int i = 0; i < Width; i++) begin
      if (Value[i]) begin
        Count   = CountWidth'(Width - 1 - i);
        AllZero = 1'b0;
      end
    end
  end

endmodule : fp_leading_zero_counter

`default_nettype wire

// File: rtl/fp_round_pack.sv
// Normalize (stage A) then round-to-nearest-even and pack (stage B) into an
// IEEE-754 single-precision word, behind a two-entry valid/ready pipeline.
`default_nettype none

module fp_round_pack
  import fp_pkg::*;
#(
  parameter int DataSize     = 32,
  parameter int FractionSize = 23,
  parameter int MantissaSize = FractionSize + 1,
  parameter int RoundingSize = MantissaSize + 3,
  parameter int ExponentSize = 8
) (
  input  logic                    Clock,
  input  logic                    ResetN,
  input  logic                    InValid,
  output logic                    InReady,
  input  logic                    InSign,
  input  logic [ExponentSize-1:0] InExponent,
  input  logic [RoundingSize:0]   InMantissa,
  output logic                    OutValid,
  input  logic                    OutReady,
  output logic [DataSize-1:0]     Result,
  output logic                    Overflow,
  output logic                    Underflow,
  output logic                    Inexact
);

  localparam int ExpWidth   = ExponentSize + 2;
  localparam int CountWidth = $clog2(HiddenBit + 1);

  logic                    valid_a_q, valid_b_q;
  logic                    sign_a_q, sign_a_d;
  logic                    zero_a_q, zero_a_d;
  logic [ExpWidth-1:0]     exp_a_q, exp_a_d;
  logic [HiddenBit:0]      man_a_q, man_a_d;
  logic [DataSize-1:0]     result_q, result_d;
  logic                    overflow_q, overflow_d;
  logic                    underflow_q, underflow_d;
  logic                    inexact_q, inexact_d;

  logic                    drain_a, accept;
  logic [CountWidth-1:0]   lz_count;
  logic                    lz_zero;
  logic [ExpWidth-1:0]     exp_in, exp_b;
  logic                    round_inc, lost_bits;
  logic [MantissaSize:0]   rounded;
  logic [FractionSize-1:0] frac_b;

  assign drain_a = valid_a_q & (~valid_b_q | OutReady);
  assign InReady = ~valid_a_q | drain_a;
  assign accept  = InValid & InReady;

  fp_leading_zero_counter #(
    .Width      (HiddenBit + 1),
    .CountWidth (CountWidth)
  ) u_lzc (
    .Value   (InMantissa[HiddenBit:0]),
    .Count   (lz_count),
    .AllZero (lz_zero)
  );

  assign exp_in = ExpWidth'(InExponent);

  always_comb begin
    sign_a_d = InSign;
    zero_a_d = 1'b0;
    exp_a_d  = exp_in;
    man_a_d  = InMantissa[HiddenBit:0];
    if (InMantissa[CarryBit]) begin
      // The bit shifted out folds into sticky so rounding still sees it.
      man_a_d = {InMantissa[CarryBit:RoundBit+1], |InMantissa[RoundBit:StickyBit]};
      exp_a_d = exp_in + ExpWidth'(1);
    end else if (!lz_zero) begin
      man_a_d = InMantissa[HiddenBit:0] << lz_count;
      exp_a_d = exp_in - ExpWidth'(lz_count);
    end else begin
      sign_a_d = 1'b0;
      zero_a_d = 1'b1;
      exp_a_d  = '0;
    end
  end

  always_comb begin
    round_inc = man_a_q[GuardBit] &
                (man_a_q[RoundBit] | man_a_q[StickyBit] | man_a_q[GuardBit+1]);
    lost_bits = |man_a_q[GuardBit:StickyBit];
    rounded   = {1'b0, man_a_q[HiddenBit:GuardBit+1]} + (MantissaSize+1)'(round_inc);
    exp_b     = exp_a_q;
    frac_b    = rounded[FractionSize-1:0];
    // A carry out of the hidden bit leaves 10.000..., renormalized to 1.0.
    if (rounded[MantissaSize]) begin
      exp_b  = exp_a_q + ExpWidth'(1);
      frac_b = rounded[FractionSize:1];
    end

    result_d    = {sign_a_q, exp_b[ExponentSize-1:0], frac_b};
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    inexact_d   = lost_bits;
    if (zero_a_q) begin
      result_d  = '0;
      inexact_d = 1'b0;
    end else if ($signed(exp_b) >= $signed(ExpWidth'(ExpMax))) begin
      result_d   = DataSize'(PosInf) | {sign_a_q, {(DataSize-1){1'b0}}};
      overflow_d = 1'b1;
      inexact_d  = 1'b1;
    end else if ($signed(exp_b) <= $signed(ExpWidth'(0))) begin
      result_d    = {sign_a_q, {(DataSize-1){1'b0}}};
      underflow_d = 1'b1;
      inexact_d   = 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      valid_a_q   <= 1'b0;
      sign_a_q    <= 1'b0;
      zero_a_q    <= 1'b0;
      exp_a_q     <= '0;
      man_a_q     <= '0;
      valid_b_q   <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      inexact_q   <= 1'b0;
    end else begin
      if (accept) begin
        valid_a_q <= 1'b1;
        sign_a_q  <= sign_a_d;
        zero_a_q  <= zero_a_d;
        exp_a_q   <= exp_a_d;
        man_a_q   <= man_a_d;
      end else if (drain_a) begin
        valid_a_q <= 1'b0;
      end

      if (drain_a) begin
        valid_b_q   <= 1'b1;
        result_q    <= result_d;
        overflow_q  <= overflow_d;
        underflow_q <= underflow_d;
        inexact_q   <= inexact_d;
      end else if (OutReady) begin
        valid_b_q <= 1'b0;
      end
    end
  end

  assign OutValid  = valid_b_q;
  assign Result    = result_q;
  assign Overflow  = overflow_q;
  assign Underflow = underflow_q;
  assign Inexact   = inexact_q;

endmodule : fp_round_pack

`default_nettype wire

// File: tb/tb_fp_round_pack.sv
// Directed self-checking bench for fp_round_pack: rounding, exceptions, handshake, reset.
`default_nettype none

module tb_fp_round_pack;

  logic        Clock = 1'b0;
  logic        ResetN;
  logic        InValid;
  logic        InReady;
  logic        InSign;
  logic [7:0]  InExponent;
  logic [27:0] InMantissa;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] Result;
  logic        Overflow;
  logic        Underflow;
  logic        Inexact;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        s;
    logic [7:0]  e;
    logic [27:0] m;
    logic [31:0] r;
    logic [2:0]  f;   // {Overflow, Underflow, Inexact}
  } vec_t;

  always #5 Clock = ~Clock;

  fp_round_pack dut (
    .Clock      (Clock),
    .ResetN     (ResetN),
    .InValid    (InValid),
    .InReady    (InReady),
    .InSign     (InSign),
    .InExponent (InExponent),
    .InMantissa (InMantissa),
    .OutValid   (OutValid),
    .OutReady   (OutReady),
    .Result     (Result),
    .Overflow   (Overflow),
    .Underflow  (Underflow),
    .Inexact    (Inexact)
  );

  // Drives one beat into an idle pipeline and waits (bounded) for its result.
  task automatic run_beat(input logic s, input logic [7:0] e, input logic [27:0] m,
                          output logic [35:0] obs, output int lat);
    @(negedge Clock);
    InSign = s; InExponent = e; InMantissa = m; InValid = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    InValid = 1'b0;
    lat = 1;
    while (OutValid !== 1'b1 && lat < 8) begin
      @(negedge Clock);
      lat++;
    end
    obs = {OutValid, Result, Overflow, Underflow, Inexact};
  endtask

  task automatic test_reset();
    ResetN = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    InSign = 1'b0; InExponent = '0; InMantissa = '0;
    repeat (2) @(negedge Clock);
    checks++;
    if ({OutValid, Result, Overflow, Underflow, Inexact} !== 36'h0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b result=%h flags=%b%b%b, want all zero",
               OutValid, Result, Overflow, Underflow, Inexact);
    end
    ResetN = 1'b1;
    #1;
    checks++;
    if (InReady !== 1'b1) begin
      errors++;
      $display("FAIL reset_inready: got %b want 1", InReady);
    end
  endtask

  task automatic test_basic();
    vec_t v[4] = '{
      '{1'b0, 8'd127, 28'h8000000, 32'h4000_0000, 3'b000},
      '{1'b0, 8'd127, 28'h0800000, 32'h3E00_0000, 3'b000},
      '{1'b1, 8'd127, 28'h4000000, 32'hBF80_0000, 3'b000},
      '{1'b0, 8'd1,   28'h4000000, 32'h0080_0000, 3'b000}
    };
    logic [35:0] obs;
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_beat(v[i].s, v[i].e, v[i].m, obs, lat);
      checks++;
      if (obs !== {1'b1, v[i].r, v[i].f}) begin
        errors++;
        $display("FAIL basic[%0d]: got valid/result/flags %h, want %h", i, obs, {1'b1, v[i].r, v[i].f});
      end
      if (i == 0) begin
        checks++;
        if (lat !== 2) begin
          errors++;
          $display("FAIL latency: got %0d edges, want 2", lat);
        end
      end
    end
  endtask

  task automatic test_rounding();
    vec_t v[7] = '{
      '{1'b0, 8'd127, 28'h4000004, 32'h3F80_0000, 3'b001},
      '{1'b0, 8'd127, 28'h400000C, 32'h3F80_0002, 3'b001},
      '{1'b0, 8'd127, 28'h4000006, 32'h3F80_0001, 3'b001},
      '{1'b0, 8'd127, 28'h4000001, 32'h3F80_0000, 3'b001},
      '{1'b0, 8'd127, 28'h7FFFFFC, 32'h4000_0000, 3'b001},
      '{1'b0, 8'd127, 28'h8000003, 32'h4000_0000, 3'b001},
      '{1'b0, 8'd127, 28'h800000C, 32'h4000_0001, 3'b001}
    };
    logic [35:0] obs;
    int lat;
    for (int i = 0; i < 7; i++) begin
      run_beat(v[i].s, v[i].e, v[i].m, obs, lat);
      checks++;
      if (obs !== {1'b1, v[i].r, v[i].f}) begin
        errors++;
        $display("FAIL round[%0d]: got valid/result/flags %h, want %h", i, obs, {1'b1, v[i].r, v[i].f});
      end
    end
  endtask

  task automatic test_exceptions();
    vec_t v[6] = '{
      '{1'b0, 8'd254, 28'h8000000, 32'h7F80_0000, 3'b101},
      '{1'b1, 8'd254, 28'h7FFFFFC, 32'hFF80_0000, 3'b101},
      '{1'b0, 8'd254, 28'h4000000, 32'h7F00_0000, 3'b000},
      '{1'b0, 8'd2,   28'h0800000, 32'h0000_0000, 3'b011},
      '{1'b1, 8'd0,   28'h4000000, 32'h8000_0000, 3'b011},
      '{1'b1, 8'd100, 28'h0000000, 32'h0000_0000, 3'b000}
    };
    logic [35:0] obs;
    int lat;
    for (int i = 0; i < 6; i++) begin
      run_beat(v[i].s, v[i].e, v[i].m, obs, lat);
      checks++;
      if (obs !== {1'b1, v[i].r, v[i].f}) begin
        errors++;
        $display("FAIL except[%0d]: got valid/result/flags %h, want %h", i, obs, {1'b1, v[i].r, v[i].f});
      end
    end
  endtask

  task automatic test_backpressure();
    int held_bad = 0;
    @(negedge Clock);
    OutReady = 1'b0;
    InSign = 1'b0; InExponent = 8'd127; InMantissa = 28'h8000000; InValid = 1'b1;
    @(negedge Clock);
    InMantissa = 28'h0800000;
    @(negedge Clock);
    InMantissa = 28'h4000000;
    checks++;
    if ({InReady, OutValid, Result} !== {2'b01, 32'h4000_0000}) begin
      errors++;
      $display("FAIL bp_full: got inready=%b valid=%b result=%h, want 0 1 40000000", InReady, OutValid, Result);
    end
    repeat (3) begin
      @(negedge Clock);
      if ({InReady, OutValid, Result} !== {2'b01, 32'h4000_0000}) held_bad++;
    end
    checks++;
    if (held_bad !== 0) begin
      errors++;
      $display("FAIL bp_hold: got %0d unstable cycles, want 0", held_bad);
    end
    OutReady = 1'b1;
    #1;
    checks++;
    if (InReady !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_inready: got %b want 1", InReady);
    end
    @(negedge Clock);
    InValid = 1'b0;
    checks++;
    if ({OutValid, Result} !== {1'b1, 32'h3E00_0000}) begin
      errors++;
      $display("FAIL bp_beat2: got valid=%b result=%h, want 1 3e000000", OutValid, Result);
    end
    @(negedge Clock);
    checks++;
    if ({OutValid, Result} !== {1'b1, 32'h3F80_0000}) begin
      errors++;
      $display("FAIL bp_beat3: got valid=%b result=%h, want 1 3f800000", OutValid, Result);
    end
    @(negedge Clock);
    checks++;
    if (OutValid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drained: got valid=%b want 0", OutValid);
    end
  endtask

  task automatic test_back_to_back();
    logic [27:0] m[4] = '{28'h8000000, 28'h0800000, 28'h4000004, 28'h400000C};
    logic [31:0] r[4] = '{32'h4000_0000, 32'h3E00_0000, 32'h3F80_0000, 32'h3F80_0002};
    int nin = 0, nout = 0, first = -1, last = -1, stall = 0;
    OutReady = 1'b1;
    repeat (2) @(negedge Clock);
    for (int cyc = 0; cyc < 12 && nout < 4; cyc++) begin
      @(negedge Clock);
      if (OutValid === 1'b1) begin
        checks++;
        if (Result !== r[nout]) begin
          errors++;
          $display("FAIL b2b[%0d]: got %h want %h", nout, Result, r[nout]);
        end
        if (first < 0) first = cyc;
        last = cyc;
        nout++;
      end
      if (nin < 4) begin
        InValid = 1'b1; InSign = 1'b0; InExponent = 8'd127; InMantissa = m[nin];
        nin++;
        #1;
        if (InReady !== 1'b1) stall++;
      end else begin
        InValid = 1'b0;
      end
    end
    InValid = 1'b0;
    checks++;
    if ({nout, last - first, stall} !== {32'd4, 32'd3, 32'd0}) begin
      errors++;
      $display("FAIL b2b_rate: got %0d beats over %0d cycles with %0d stalls, want 4 over 3 with 0",
               nout, last - first, stall);
    end
  endtask

  task automatic test_reset_midstream();
    logic [35:0] obs;
    int lat;
    int stale = 0;
    @(negedge Clock);
    OutReady = 1'b0;
    InSign = 1'b0; InExponent = 8'd127; InMantissa = 28'h8000000; InValid = 1'b1;
    @(negedge Clock);
    InMantissa = 28'h0800000;
    @(negedge Clock);
    InValid = 1'b0;
    #2 ResetN = 1'b0;
    #1;
    checks++;
    if ({OutValid, Result} !== 33'h0) begin
      errors++;
      $display("FAIL midreset_async: got valid=%b result=%h, want 0 00000000", OutValid, Result);
    end
    @(negedge Clock);
    ResetN = 1'b1;
    OutReady = 1'b1;
    repeat (5) begin
      @(negedge Clock);
      if (OutValid !== 1'b0) stale++;
    end
    checks++;
    if (stale !== 0) begin
      errors++;
      $display("FAIL midreset_stale: got %0d stale valid cycles, want 0", stale);
    end
    run_beat(1'b0, 8'd127, 28'h4000000, obs, lat);
    checks++;
    if (obs !== {1'b1, 32'h3F80_0000, 3'b000}) begin
      errors++;
      $display("FAIL midreset_fresh: got %h want %h", obs, {1'b1, 32'h3F80_0000, 3'b000});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_exceptions();
    test_backpressure();
    test_back_to_back();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_fp_round_pack

`default_nettype wire
